// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-cycle MUL/DIVU/REMU sequencer.
package alu_seq_pkg;

    localparam int ITERS_DEF = 32;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REMU = 2'd2;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving an external ALU through ADD/SUB steps for MUL, DIVU and REMU.
// Divide support is compiled in only when ALU_SEQ_DIV_EN is defined.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int ITERS = ITERS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic [31:0]   result_reg;
    logic          err_reg;
    logic [31:0]   acc_reg;
    logic [31:0]   mcand_reg;
    logic [31:0]   mplier_reg;
    logic [31:0]   acc_next;

`ifdef ALU_SEQ_DIV_EN
    logic [1:0]    op_reg;
    logic [31:0]   rem_reg;
    logic [31:0]   quo_reg;
    logic [31:0]   divisor_reg;
    logic [32:0]   shifted;
    logic          div_ge;
    logic [31:0]   rem_next;
    logic [31:0]   quo_next;
`endif

    always_comb begin
        acc_next    = mplier_reg[0] ? alu_result : acc_reg;
        alu_control = 4'd0;
        alu_op1     = 32'd0;
        alu_op2     = 32'd0;
`ifdef ALU_SEQ_DIV_EN
        shifted  = {rem_reg, quo_reg[31]};
        // 33-bit compare: the shifted-out bit can make the partial remainder exceed 2^32-1
        div_ge   = (shifted >= {1'b0, divisor_reg});
        rem_next = div_ge ? alu_result : shifted[31:0];
        quo_next = {quo_reg[30:0], div_ge};
        if (state_reg == CALC) begin
            if (op_reg == OP_MUL) begin
                alu_control = ALU_ADD;
                alu_op1     = acc_reg;
                alu_op2     = mcand_reg;
            end else begin
                alu_control = ALU_SUB;
                alu_op1     = shifted[31:0];
                alu_op2     = divisor_reg;
            end
        end
`else
        if (state_reg == CALC) begin
            alu_control = ALU_ADD;
            alu_op1     = acc_reg;
            alu_op2     = mcand_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            result_reg    <= '0;
            err_reg       <= 1'b0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
`ifdef ALU_SEQ_DIV_EN
            op_reg        <= OP_MUL;
            rem_reg       <= '0;
            quo_reg       <= '0;
            divisor_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        req_ready_reg <= 1'b0;
                        count_reg     <= '0;
                        acc_reg       <= '0;
                        mcand_reg     <= req_a;
                        mplier_reg    <= req_b;
`ifdef ALU_SEQ_DIV_EN
                        op_reg        <= req_op;
                        rem_reg       <= '0;
                        quo_reg       <= req_a;
                        divisor_reg   <= req_b;
`endif
                        case (req_op)
                            OP_MUL: state_reg <= CALC;
`ifdef ALU_SEQ_DIV_EN
                            OP_DIVU, OP_REMU: begin
                                if (req_b == 32'd0) begin
                                    state_reg     <= DONE;
                                    rsp_valid_reg <= 1'b1;
                                    err_reg       <= 1'b1;
                                    result_reg    <= (req_op == OP_DIVU) ? 32'hFFFF_FFFF : req_a;
                                end else begin
                                    state_reg <= CALC;
                                end
                            end
`endif
                            default: begin
                                state_reg     <= DONE;
                                rsp_valid_reg <= 1'b1;
                                err_reg       <= 1'b1;
                                result_reg    <= '0;
                            end
                        endcase
                    end
                end
                CALC: begin
                    count_reg  <= count_reg + 1'b1;
                    acc_reg    <= acc_next;
                    mcand_reg  <= {mcand_reg[30:0], 1'b0};
                    mplier_reg <= {1'b0, mplier_reg[31:1]};
`ifdef ALU_SEQ_DIV_EN
                    rem_reg    <= rem_next;
                    quo_reg    <= quo_next;
`endif
                    if (count_reg == LAST) begin
                        count_reg     <= '0;
                        state_reg     <= DONE;
                        rsp_valid_reg <= 1'b1;
                        err_reg       <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                        case (op_reg)
                            OP_DIVU: result_reg <= quo_next;
                            OP_REMU: result_reg <= rem_next;
                            default: result_reg <= acc_next;
                        endcase
`else
                        result_reg    <= acc_next;
`endif
                    end
                end
                DONE: begin
                    // req_ready comes back one cycle after the response handshake
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    req_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = result_reg;
    assign rsp_err    = err_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU attached to the alu_* ports.
// Expectations follow ALU_SEQ_DIV_EN when it is defined for the build.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  alu_control;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_result;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [31:0] result;
        logic        err;
        logic [31:0] latency;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .alu_control(alu_control),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_control)
            4'd0:    alu_result = alu_op1 & alu_op2;
            4'd1:    alu_result = alu_op1 | alu_op2;
            4'd2:    alu_result = alu_op1 + alu_op2;
            4'd3:    alu_result = alu_op1 - alu_op2;
            default: alu_result = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.err = 1'b1;
        e.result = 32'd0;
        e.latency = 32'd1;
        if (op == 2'd0) begin
            e.result = a * b;
            e.err = 1'b0;
            e.latency = 32'd33;
        end
`ifdef ALU_SEQ_DIV_EN
        else if (op == 2'd1 || op == 2'd2) begin
            if (b == 32'd0) begin
                e.result = (op == 2'd1) ? 32'hFFFF_FFFF : a;
            end else begin
                e.result = (op == 2'd1) ? a / b : a % b;
                e.err = 1'b0;
                e.latency = 32'd33;
            end
        end
`endif
        return e;
    endfunction

    // Drive one request, then wait for its response and compare against the scoreboard head.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        exp_t e;
        int   edges;
        logic [31:0] held;
        rsp_ready = (hold == 0);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        #1;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb_q.push_back(model(op, a, b));
        edges = 0;
        while (!rsp_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
            return;
        end
        e = sb_q.pop_front();
        check("latency", 32'(edges + 1), e.latency);
        check("result", rsp_result, e.result);
        check("err", {31'd0, rsp_err}, {31'd0, e.err});
        $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h err=%0b lat=%0d", op, a, b, rsp_result, rsp_err, edges + 1);
        held = rsp_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_result", rsp_result, held);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        check("rst_alu_ctl", {28'd0, alu_control}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(2'd0, 32'd7, 32'd6, 0);
        send(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        send(2'd0, 32'h0001_0000, 32'h0001_0000, 0);
        send(2'd1, 32'd100, 32'd7, 0);
        send(2'd2, 32'd100, 32'd7, 0);
        send(2'd1, 32'hFFFF_FFFF, 32'd1, 0);
        send(2'd1, 32'd5, 32'd0, 0);
        send(2'd2, 32'd5, 32'd0, 0);
        send(2'd3, 32'd9, 32'd4, 0);
        send(2'd0, 32'd12345, 32'd678, 5);
        for (int i = 0; i < 6; i++) begin
            send(2'($urandom_range(0, 2)), $urandom, $urandom_range(1, 32'h7FFF_FFFF), 0);
        end
        send(2'd2, 32'hFFFF_FFFF, 32'h8000_0001, 0);

        // Reset in the middle of a multiply
        req_op    = 2'd0;
        req_a     = 32'd1000;
        req_b     = 32'd1000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_calc_alu_ctl", {28'd0, alu_control}, 32'd2);
        check("mid_calc_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_alu_ctl", {28'd0, alu_control}, 32'd0);
        check("mid_rst_alu_op1", alu_op1, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        send(2'd0, 32'd3, 32'd5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
